// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the pipelined CPU datapath: ALU ops,
//               operand-forwarding selects and NZCV flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int unsigned C_XLEN = 64;
    localparam int unsigned C_RIDX = 5;

    localparam int unsigned C_FLAG_N = 3;
    localparam int unsigned C_FLAG_Z = 2;
    localparam int unsigned C_FLAG_C = 1;
    localparam int unsigned C_FLAG_V = 0;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_XOR   = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_IDEX  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_WB    = 2'b10,
        FWD_RSVD  = 2'b11
    } fwd_sel_e;

    // The reserved select falls back to the ID/EX value.
    function automatic logic [C_XLEN-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [C_XLEN-1:0] idex_val,
        input logic [C_XLEN-1:0] exmem_val,
        input logic [C_XLEN-1:0] wb_val
    );
        case (sel)
            FWD_EXMEM: return exmem_val;
            FWD_WB:    return wb_val;
            default:   return idex_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : ID/EX inputs and EX/MEM outputs of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
    import cpu_pkg::*;

    logic              enable;
    logic              flush;
    logic              valid_in;
    logic [C_XLEN-1:0] reg1_in;
    logic [C_XLEN-1:0] reg2_in;
    logic [C_XLEN-1:0] imm_in;
    logic [C_XLEN-1:0] pc_plus4_in;
    logic [C_RIDX-1:0] rd_in;
    logic [2:0]        ex_alu_op_in;
    logic              ex_alu_src_in;
    logic              ex_flag_write_in;
    logic              ex_is_cbz_in;
    logic              ex_is_blt_in;
    logic              mem_mem_read_in;
    logic              mem_mem_write_in;
    logic              mem_uncond_branch_in;
    logic              mem_reg_branch_in;
    logic              wb_reg_write_in;
    logic              wb_mem_to_reg_in;
    logic              wb_link_write_in;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [C_XLEN-1:0] wb_data_in;

    logic              valid_out;
    logic [C_XLEN-1:0] alu_result_out;
    logic [C_XLEN-1:0] store_data_out;
    logic [C_XLEN-1:0] pc_plus4_out;
    logic [C_XLEN-1:0] br_target_out;
    logic [C_RIDX-1:0] rd_out;
    logic              br_taken_out;
    logic [3:0]        flags_out;
    logic              mem_mem_read_out;
    logic              mem_mem_write_out;
    logic              wb_reg_write_out;
    logic              wb_mem_to_reg_out;
    logic              wb_link_write_out;

    modport slave (
        input  enable, flush, valid_in, reg1_in, reg2_in, imm_in, pc_plus4_in, rd_in,
               ex_alu_op_in, ex_alu_src_in, ex_flag_write_in, ex_is_cbz_in, ex_is_blt_in,
               mem_mem_read_in, mem_mem_write_in, mem_uncond_branch_in, mem_reg_branch_in,
               wb_reg_write_in, wb_mem_to_reg_in, wb_link_write_in,
               fwd_a_sel, fwd_b_sel, wb_data_in,
        output valid_out, alu_result_out, store_data_out, pc_plus4_out, br_target_out,
               rd_out, br_taken_out, flags_out, mem_mem_read_out, mem_mem_write_out,
               wb_reg_write_out, wb_mem_to_reg_out, wb_link_write_out
    );

    modport master (
        output enable, flush, valid_in, reg1_in, reg2_in, imm_in, pc_plus4_in, rd_in,
               ex_alu_op_in, ex_alu_src_in, ex_flag_write_in, ex_is_cbz_in, ex_is_blt_in,
               mem_mem_read_in, mem_mem_write_in, mem_uncond_branch_in, mem_reg_branch_in,
               wb_reg_write_in, wb_mem_to_reg_in, wb_link_write_in,
               fwd_a_sel, fwd_b_sel, wb_data_in,
        input  valid_out, alu_result_out, store_data_out, pc_plus4_out, br_target_out,
               rd_out, br_taken_out, flags_out, mem_mem_read_out, mem_mem_write_out,
               wb_reg_write_out, wb_mem_to_reg_out, wb_link_write_out
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 64-bit ALU with NZCV flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import cpu_pkg::*;
(
    input  logic [C_XLEN-1:0] a,
    input  logic [C_XLEN-1:0] b,
    input  logic [2:0]        op,
    output logic [C_XLEN-1:0] result,
    output logic [3:0]        flags
);
    logic [C_XLEN:0] w_sum;
    logic            w_c;
    logic            w_v;

    always_comb begin
        w_sum  = '0;
        result = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op)
            ALU_PASSB: result = b;
            ALU_ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[C_XLEN-1:0];
                w_c    = w_sum[C_XLEN];
                w_v    = (a[C_XLEN-1] == b[C_XLEN-1]) && (result[C_XLEN-1] != a[C_XLEN-1]);
            end
            ALU_SUB: begin
                // Carry is the no-borrow bit of A + ~B + 1.
                w_sum  = {1'b0, a} + {1'b0, ~b} + {{C_XLEN{1'b0}}, 1'b1};
                result = w_sum[C_XLEN-1:0];
                w_c    = w_sum[C_XLEN];
                w_v    = (a[C_XLEN-1] != b[C_XLEN-1]) && (result[C_XLEN-1] != a[C_XLEN-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase

        flags           = '0;
        flags[C_FLAG_N] = result[C_XLEN-1];
        flags[C_FLAG_Z] = (result == '0);
        flags[C_FLAG_C] = w_c;
        flags[C_FLAG_V] = w_v;
    end
endmodule
`default_nettype wire

// File: rtl/register_cells.sv
`default_nettype none
// ============================================================================
// Module      : register_64bit / register_5bit / register_1bit
// Description : Enabled storage cells with asynchronous active-high clear.
// Revision    : 1.0 - initial release
// ============================================================================
module register_64bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] d,
    output logic [63:0] q
);
    logic [63:0] data_d, data_q;

    always_comb data_d = enable ? d : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule

module register_5bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] d,
    output logic [4:0] q
);
    logic [4:0] data_d, data_q;

    always_comb data_d = enable ? d : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule

module register_1bit (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic d,
    output logic q
);
    logic data_d, data_q;

    always_comb data_d = enable ? d : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= 1'b0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage: forwarding, ALU, NZCV flags, branch resolve,
//               EX/MEM boundary register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam int unsigned C_NCTL = 7;

    logic [C_XLEN-1:0] w_op_a, w_fwd_b, w_alu_b, w_alu_res;
    logic [3:0]        w_alu_flags, flags_q;
    logic              w_flag_en, w_cbz_hit, w_blt_hit, w_taken;
    logic [C_XLEN-1:0] alu_result_d, store_data_d, pc_plus4_d, br_target_d;
    logic [C_XLEN-1:0] alu_result_q, store_data_q, pc_plus4_q, br_target_q;
    logic [C_RIDX-1:0] rd_d, rd_q;
    logic              valid_d;
    logic [C_NCTL-1:0] ctl_d, ctl_q;

    // Select 01 taps the registered result, so this path has no comb loop.
    always_comb begin
        w_op_a  = fwd_mux(bus.fwd_a_sel, bus.reg1_in, alu_result_q, bus.wb_data_in);
        w_fwd_b = fwd_mux(bus.fwd_b_sel, bus.reg2_in, alu_result_q, bus.wb_data_in);
        w_alu_b = bus.ex_alu_src_in ? bus.imm_in : w_fwd_b;
    end

    alu u_alu (
        .a      (w_op_a),
        .b      (w_alu_b),
        .op     (bus.ex_alu_op_in),
        .result (w_alu_res),
        .flags  (w_alu_flags)
    );

    // Branches test the committed flag register, never this cycle's ALU flags.
    always_comb begin
        w_flag_en    = bus.enable & bus.valid_in & bus.ex_flag_write_in & ~bus.flush;
        w_cbz_hit    = bus.ex_is_cbz_in & (w_fwd_b == '0);
        w_blt_hit    = bus.ex_is_blt_in & (flags_q[C_FLAG_N] ^ flags_q[C_FLAG_V]);
        w_taken      = bus.valid_in & (bus.mem_uncond_branch_in | bus.mem_reg_branch_in
                                       | w_cbz_hit | w_blt_hit);
        valid_d      = bus.valid_in & ~bus.flush;
        alu_result_d = w_alu_res;
        store_data_d = w_fwd_b;
        pc_plus4_d   = bus.pc_plus4_in;
        br_target_d  = bus.mem_reg_branch_in ? w_op_a
                                             : bus.pc_plus4_in + bus.imm_in - C_XLEN'(4);
        rd_d         = bus.rd_in;
        ctl_d        = {bus.wb_link_write_in,
                        bus.wb_mem_to_reg_in,
                        bus.wb_reg_write_in & valid_d,
                        bus.mem_mem_write_in & valid_d,
                        bus.mem_mem_read_in,
                        w_taken & valid_d,
                        valid_d};
    end

    register_64bit u_alu_result (.clk(clk), .reset(reset), .enable(bus.enable), .d(alu_result_d), .q(alu_result_q));
    register_64bit u_store_data (.clk(clk), .reset(reset), .enable(bus.enable), .d(store_data_d), .q(store_data_q));
    register_64bit u_pc_plus4   (.clk(clk), .reset(reset), .enable(bus.enable), .d(pc_plus4_d),   .q(pc_plus4_q));
    register_64bit u_br_target  (.clk(clk), .reset(reset), .enable(bus.enable), .d(br_target_d),  .q(br_target_q));
    register_5bit  u_rd         (.clk(clk), .reset(reset), .enable(bus.enable), .d(rd_d),         .q(rd_q));

    for (genvar i = 0; i < C_NCTL; i++) begin : g_ctl
        register_1bit u_bit (.clk(clk), .reset(reset), .enable(bus.enable), .d(ctl_d[i]), .q(ctl_q[i]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_flags
        register_1bit u_bit (.clk(clk), .reset(reset), .enable(w_flag_en), .d(w_alu_flags[i]), .q(flags_q[i]));
    end

    assign bus.alu_result_out    = alu_result_q;
    assign bus.store_data_out    = store_data_q;
    assign bus.pc_plus4_out      = pc_plus4_q;
    assign bus.br_target_out     = br_target_q;
    assign bus.rd_out            = rd_q;
    assign bus.flags_out         = flags_q;
    assign bus.valid_out         = ctl_q[0];
    assign bus.br_taken_out      = ctl_q[1];
    assign bus.mem_mem_read_out  = ctl_q[2];
    assign bus.mem_mem_write_out = ctl_q[3];
    assign bus.wb_reg_write_out  = ctl_q[4];
    assign bus.wb_mem_to_reg_out = ctl_q[5];
    assign bus.wb_link_write_out = ctl_q[6];
endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

    // br = {reg_branch, uncond, blt, cbz}; ctl = {mem_read, mem_write, reg_write, mem_to_reg, link_write}
    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic        src, fw;
        logic [3:0]  br;
        logic [1:0]  fa, fb;
        logic [63:0] reg1, reg2, imm, pc4, wbd;
        logic [4:0]  ctl, rd;
        logic        e_valid;
        logic [63:0] e_res, e_store, e_tgt, e_pc4;
        logic        e_taken;
        logic [3:0]  e_flags;
        logic [4:0]  e_ctl, e_rd;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[20];

    function automatic vec_t mk(
        input logic valid, input logic [2:0] op, input logic src, input logic fw,
        input logic [3:0] br, input logic [1:0] fa, input logic [1:0] fb,
        input logic [63:0] reg1, input logic [63:0] reg2, input logic [63:0] imm,
        input logic [63:0] pc4, input logic [63:0] wbd, input logic [4:0] ctl, input logic [4:0] rd,
        input logic e_valid, input logic [63:0] e_res, input logic [63:0] e_store,
        input logic [63:0] e_tgt, input logic e_taken, input logic [3:0] e_flags, input logic [4:0] e_ctl
    );
        vec_t v;
        v.valid = valid; v.op = op; v.src = src; v.fw = fw; v.br = br; v.fa = fa; v.fb = fb;
        v.reg1 = reg1; v.reg2 = reg2; v.imm = imm; v.pc4 = pc4; v.wbd = wbd; v.ctl = ctl; v.rd = rd;
        v.e_valid = e_valid; v.e_res = e_res; v.e_store = e_store; v.e_tgt = e_tgt; v.e_pc4 = pc4;
        v.e_taken = e_taken; v.e_flags = e_flags; v.e_ctl = e_ctl; v.e_rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic compare_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard: got empty queue, expected a pending entry");
            return;
        end
        e = exp_q.pop_front();
        check("valid_out",      64'(bus.valid_out),      64'(e.e_valid));
        check("alu_result_out", bus.alu_result_out,      e.e_res);
        check("store_data_out", bus.store_data_out,      e.e_store);
        check("pc_plus4_out",   bus.pc_plus4_out,        e.e_pc4);
        check("br_target_out",  bus.br_target_out,       e.e_tgt);
        check("br_taken_out",   64'(bus.br_taken_out),   64'(e.e_taken));
        check("flags_out",      64'(bus.flags_out),      64'(e.e_flags));
        check("rd_out",         64'(bus.rd_out),         64'(e.e_rd));
        check("ctl_out", 64'({bus.mem_mem_read_out, bus.mem_mem_write_out, bus.wb_reg_write_out,
                              bus.wb_mem_to_reg_out, bus.wb_link_write_out}), 64'(e.e_ctl));
    endtask

    task automatic drive(input vec_t v, input logic en, input logic fl);
        bus.enable = en; bus.flush = fl; bus.valid_in = v.valid;
        bus.ex_alu_op_in = v.op; bus.ex_alu_src_in = v.src; bus.ex_flag_write_in = v.fw;
        {bus.mem_reg_branch_in, bus.mem_uncond_branch_in, bus.ex_is_blt_in, bus.ex_is_cbz_in} = v.br;
        bus.fwd_a_sel = v.fa; bus.fwd_b_sel = v.fb;
        bus.reg1_in = v.reg1; bus.reg2_in = v.reg2; bus.imm_in = v.imm;
        bus.pc_plus4_in = v.pc4; bus.wb_data_in = v.wbd; bus.rd_in = v.rd;
        {bus.mem_mem_read_in, bus.mem_mem_write_in, bus.wb_reg_write_in,
         bus.wb_mem_to_reg_in, bus.wb_link_write_in} = v.ctl;
    endtask

    task automatic apply(input vec_t v, input logic en, input logic fl);
        drive(v, en, fl);
        exp_q.push_back(v);
        @(posedge clk); #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid_out"},  64'(bus.valid_out),    64'd0);
        check({tag, " alu_result"}, bus.alu_result_out,    64'd0);
        check({tag, " store_data"}, bus.store_data_out,    64'd0);
        check({tag, " pc_plus4"},   bus.pc_plus4_out,      64'd0);
        check({tag, " br_target"},  bus.br_target_out,     64'd0);
        check({tag, " rd_out"},     64'(bus.rd_out),       64'd0);
        check({tag, " br_taken"},   64'(bus.br_taken_out), 64'd0);
        check({tag, " flags_out"},  64'(bus.flags_out),    64'd0);
        check({tag, " ctl_out"}, 64'({bus.mem_mem_read_out, bus.mem_mem_write_out, bus.wb_reg_write_out,
                                      bus.wb_mem_to_reg_out, bus.wb_link_write_out}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //             vld op    src fw br     fa     fb     reg1                    reg2                    imm                     pc4        wbd     ctl       rd   | ev  res                     store      tgt       tk flags    ectl
        tbl[0]  = mk(1, 3'b010, 0, 0, 4'b0000, 2'b00, 2'b00, 64'd5,                  64'd7,                  64'd0,                  64'h10,    64'd0,   5'b00100, 5'd3, 1, 64'd12,                 64'd7,     64'hC,     0, 4'b0000, 5'b00100);
        tbl[1]  = mk(1, 3'b010, 0, 0, 4'b0000, 2'b00, 2'b00, 64'd4,                  64'd6,                  64'd0,                  64'h4,     64'd0,   5'b00000, 5'd4, 1, 64'd10,                 64'd6,     64'h0,     0, 4'b0000, 5'b00000);
        tbl[2]  = mk(1, 3'b010, 0, 0, 4'b0000, 2'b01, 2'b00, 64'd99,                 64'd1,                  64'd0,                  64'h4,     64'd0,   5'b00000, 5'd5, 1, 64'd11,                 64'd1,     64'h0,     0, 4'b0000, 5'b00000);
        tbl[3]  = mk(1, 3'b011, 0, 1, 4'b0000, 2'b00, 2'b00, 64'd3,                  64'd5,                  64'd0,                  64'h4,     64'd0,   5'b00000, 5'd6, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5,    64'h0,     0, 4'b1000, 5'b00000);
        tbl[4]  = mk(1, 3'b000, 1, 0, 4'b0010, 2'b00, 2'b00, 64'd0,                  64'd0,                  64'h20,                 64'h104,   64'd0,   5'b00000, 5'd0, 1, 64'h20,                 64'd0,     64'h120,   1, 4'b1000, 5'b00000);
        tbl[5]  = mk(1, 3'b000, 0, 0, 4'b0001, 2'b00, 2'b10, 64'd0,                  64'd9,                  64'h40,                 64'h200,   64'd0,   5'b00000, 5'd0, 1, 64'd0,                  64'd0,     64'h23C,   1, 4'b1000, 5'b00000);
        tbl[6]  = mk(1, 3'b011, 0, 1, 4'b0000, 2'b00, 2'b00, 64'd5,                  64'd5,                  64'd0,                  64'h4,     64'd0,   5'b00000, 5'd7, 1, 64'd0,                  64'd5,     64'h0,     0, 4'b0110, 5'b00000);
        tbl[7]  = mk(1, 3'b010, 0, 1, 4'b0000, 2'b00, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 64'd0,                  64'h4,     64'd0,   5'b00000, 5'd8, 1, 64'h8000_0000_0000_0000, 64'd1,    64'h0,     0, 4'b1001, 5'b00000);
        tbl[8]  = mk(1, 3'b000, 0, 0, 4'b0010, 2'b00, 2'b00, 64'd0,                  64'd3,                  64'h20,                 64'h104,   64'd0,   5'b00000, 5'd0, 1, 64'd3,                  64'd3,     64'h120,   0, 4'b1001, 5'b00000);
        tbl[9]  = mk(1, 3'b010, 0, 1, 4'b0000, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'd0,                  64'h4,     64'd0,   5'b00000, 5'd9, 1, 64'd0,                  64'd1,     64'h0,     0, 4'b0110, 5'b00000);
        tbl[10] = mk(1, 3'b100, 0, 1, 4'b0000, 2'b00, 2'b00, 64'hF0F0,               64'hFF00,               64'd0,                  64'h4,     64'd0,   5'b00000, 5'd10, 1, 64'hF000,              64'hFF00,  64'h0,     0, 4'b0000, 5'b00000);
        tbl[11] = mk(1, 3'b101, 0, 0, 4'b0000, 2'b00, 2'b00, 64'hF0,                 64'h0F,                 64'd0,                  64'h4,     64'd0,   5'b00000, 5'd11, 1, 64'hFF,                64'h0F,    64'h0,     0, 4'b0000, 5'b00000);
        tbl[12] = mk(1, 3'b110, 0, 0, 4'b0000, 2'b00, 2'b00, 64'hFF,                 64'h0F,                 64'd0,                  64'h4,     64'd0,   5'b00000, 5'd12, 1, 64'hF0,                64'h0F,    64'h0,     0, 4'b0000, 5'b00000);
        tbl[13] = mk(1, 3'b111, 0, 0, 4'b0000, 2'b00, 2'b00, 64'd5,                  64'd6,                  64'd0,                  64'h4,     64'd0,   5'b00000, 5'd13, 1, 64'd0,                 64'd6,     64'h0,     0, 4'b0000, 5'b00000);
        tbl[14] = mk(1, 3'b000, 0, 0, 4'b1000, 2'b00, 2'b00, 64'hDEAD0,              64'd0,                  64'd0,                  64'h4,     64'd0,   5'b11111, 5'd30, 1, 64'd0,                 64'd0,     64'hDEAD0, 1, 4'b0000, 5'b11111);
        tbl[15] = mk(0, 3'b000, 0, 0, 4'b1000, 2'b00, 2'b00, 64'hDEAD0,              64'd0,                  64'd0,                  64'h4,     64'd0,   5'b11111, 5'd30, 0, 64'd0,                 64'd0,     64'hDEAD0, 0, 4'b0000, 5'b10011);
        tbl[16] = mk(1, 3'b000, 0, 0, 4'b0100, 2'b00, 2'b00, 64'd0,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFF8, 64'h1000, 64'd0,   5'b00000, 5'd0, 1, 64'd0,                  64'd0,     64'hFF4,   1, 4'b0000, 5'b00000);
        tbl[17] = mk(1, 3'b000, 0, 0, 4'b0000, 2'b11, 2'b11, 64'h44,                 64'h33,                 64'd0,                  64'h4,     64'h77,  5'b00000, 5'd1, 1, 64'h33,                 64'h33,    64'h0,     0, 4'b0000, 5'b00000);
        tbl[18] = mk(1, 3'b010, 0, 0, 4'b0000, 2'b10, 2'b00, 64'h5,                  64'd1,                  64'd0,                  64'h4,     64'h100, 5'b00000, 5'd2, 1, 64'h101,                64'd1,     64'h0,     0, 4'b0000, 5'b00000);
        tbl[19] = mk(1, 3'b010, 1, 0, 4'b0000, 2'b01, 2'b00, 64'd0,                  64'h22,                 64'h10,                 64'h14,    64'd0,   5'b00000, 5'd3, 1, 64'h111,                64'h22,    64'h20,    0, 4'b0000, 5'b00000);

        reset = 1'b1;
        drive(tbl[0], 1'b0, 1'b0);
        #12;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 20; i++) apply(tbl[i], 1'b1, 1'b0);

        // Flag-setting SUBS, then a 3-cycle stall with changing inputs.
        v = mk(1, 3'b011, 0, 1, 4'b0000, 2'b00, 2'b00, 64'd3, 64'd5, 64'd0, 64'h4, 64'd0, 5'b00100, 5'd6,
               1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'h0, 0, 4'b1000, 5'b00100);
        apply(v, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vec_t s;
            s = v;
            s.reg1 = 64'(i + 40); s.reg2 = 64'(i + 1); s.op = 3'b010; s.pc4 = 64'(i * 8 + 64);
            s.rd = 5'(i + 20); s.br = 4'b0100; s.ctl = 5'b11011;
            apply(s, 1'b0, 1'(i % 2));
        end

        // Flush of a valid SUBS: bubble, no flag write, data still captured.
        v = mk(1, 3'b011, 0, 1, 4'b0000, 2'b00, 2'b00, 64'd5, 64'd5, 64'd0, 64'h8, 64'd0, 5'b01100, 5'd9,
               0, 64'd0, 64'd5, 64'h4, 0, 4'b1000, 5'b00000);
        apply(v, 1'b1, 1'b1);

        // Asynchronous reset asserted mid-cycle, released before the next edge.
        v = mk(1, 3'b010, 0, 0, 4'b0000, 2'b00, 2'b00, 64'd1, 64'd2, 64'd0, 64'h4, 64'd0, 5'b00100, 5'd1,
               1, 64'd3, 64'd2, 64'h0, 0, 4'b1000, 5'b00100);
        apply(v, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        #1 reset = 1'b0;
        v = mk(1, 3'b010, 0, 0, 4'b0000, 2'b00, 2'b00, 64'd2, 64'd2, 64'd0, 64'h4, 64'd0, 5'b00100, 5'd2,
               1, 64'd4, 64'd2, 64'h0, 0, 4'b0000, 5'b00100);
        apply(v, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined CPU: consumes the ID/EX pipeline register outputs, resolves operand forwarding, runs the ALU, maintains the architectural NZCV flag register, resolves CBZ/B.LT/B/BR, and registers everything into the EX/MEM boundary. Output is the EX/MEM register contents, so the MEM stage reads only `*_out` ports.

## Interface
- Parameters: none (datapath fixed at 64 bits, register index 5 bits).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: 0 = stall, hold all state including flags.
- `flush` in 1: kill the instruction entering EX/MEM this cycle.
- `valid_in` in 1: ID/EX slot holds a real instruction.
- `reg1_in`, `reg2_in`, `imm_in`, `pc_plus4_in` in 64 each: ID/EX data.
- `rd_in` in 5: destination register.
- `ex_alu_op_in` in 3: ALU op.
- `ex_alu_src_in` in 1: 1 = B operand is `imm_in`.
- `ex_flag_write_in`, `ex_is_cbz_in`, `ex_is_blt_in` in 1 each: EX controls.
- `mem_mem_read_in`, `mem_mem_write_in`, `mem_uncond_branch_in`, `mem_reg_branch_in` in 1 each: MEM controls.
- `wb_reg_write_in`, `wb_mem_to_reg_in`, `wb_link_write_in` in 1 each: WB controls.
- `fwd_a_sel`, `fwd_b_sel` in 2: 00 ID/EX value, 01 `alu_result_out`, 10 `wb_data_in`, 11 reserved (treated as 00).
- `wb_data_in` in 64: MEM/WB writeback value.
- `valid_out` out 1: EX/MEM slot valid.
- `alu_result_out`, `store_data_out`, `pc_plus4_out`, `br_target_out` out 64 each.
- `rd_out` out 5.
- `br_taken_out` out 1: branch resolved taken.
- `flags_out` out 4: {N,Z,C,V} architectural flags.
- `mem_*_out`, `wb_*_out` out 1 each: MEM/WB controls passed through (mem_read, mem_write, reg_write, mem_to_reg, link_write).

## Operation
- Operand A = fwd mux(`reg1_in`) per `fwd_a_sel`. Forwarded B (`fb`) = fwd mux(`reg2_in`) per `fwd_b_sel`. ALU B = `ex_alu_src_in` ? `imm_in` : `fb`.
- ALU ops: 000 pass B, 010 A+B, 011 A−B, 100 AND, 101 OR, 110 XOR. Others give result 0. Arithmetic is 64-bit wrap.
- ALU flags: N = result[63]; Z = result==0; C = carry-out (sub is A+~B+1); V = signed overflow. Logical ops give C=V=0.
- Flag register captures ALU flags at the clock edge when `enable & valid_in & ex_flag_write_in & ~flush`.
- Branch resolution uses the flag register's current value, not this cycle's ALU flags:
  - cbz_hit = `ex_is_cbz_in` & (`fb`==0).
  - blt_hit = `ex_is_blt_in` & (N≠V).
  - taken = `valid_in` & (`mem_uncond_branch_in` | `mem_reg_branch_in` | cbz_hit | blt_hit).
- `br_target_out` = `mem_reg_branch_in` ? A : `pc_plus4_in` − 4 + `imm_in` (imm already byte-scaled).
- `store_data_out` = `fb`.
- EX/MEM capture when `enable`:
  - `valid_out` ← `valid_in & ~flush`.
  - Data and controls are captured unchanged.
  - `br_taken_out`, `mem_mem_write_out` and `wb_reg_write_out` are ANDed with the captured valid, so bubbles have no side effects.

## Timing
- Latency 1 cycle: inputs at edge n appear on outputs after edge n+1. `flags_out` updates at the same edge.
- B.LT directly behind a flag-setting instruction sees that instruction's flags, because the flags were written one edge earlier. No flag bypass is needed.
- `enable`=0: every output and the flags hold. `flush` is ignored while stalled.
- `flush` with `enable`=1: `valid_out`=0 and no flag write, regardless of `valid_in`.
- Reset (any time, including mid-stall): all outputs and flags go to 0 immediately. The first edge after deassertion captures normally.
- Forward select 01 reads this block's own registered `alu_result_out` (the previous instruction). This path is combinational with no loop, because it is sourced from a flop.

## Structure
- Shared package `cpu_pkg`: ALU op encodings, forward-select encodings, and flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-module `alu` (64-bit, op + flags).
- The EX/MEM boundary and flags are built from the existing `register_64bit` / `register_5bit` / `register_1bit` cells.

## Test plan
- Reset, then ADD (reg1=5, reg2=7, op 010, valid):
  - After 1 edge: `alu_result_out`=12, `valid_out`=1.
  - Assert reset mid-cycle: all outputs 0 asynchronously.
- SUBS 3−5 with flag_write, then B.LT (pc_plus4=0x104, imm=0x20):
  - `flags_out`=1000.
  - `br_taken_out`=1, `br_target_out`=0x120.
- CBZ with `fwd_b_sel`=10, `wb_data_in`=0, reg2_in=9:
  - `br_taken_out`=1, `store_data_out`=0.
- Back-to-back dependent ADDs, `fwd_a_sel`=01:
  - Second result = first result + reg2 (10+1 → 11).
- Stall 3 cycles with changing inputs:
  - Outputs and flags constant.
  - Flush with SUBS valid: `valid_out`=0, `flags_out` unchanged, `wb_reg_write_out`=0.
- BR with reg1=0xDEAD0 → `br_target_out`=0xDEAD0, `br_taken_out`=1.
  - Same with `valid_in`=0 → `br_taken_out`=0.
